// File: rtl/fb_pixel_writer.sv
// ----------------------------------------------------------------------------
// fb_pixel_writer
//
// Avalon-MM write master that places 16-bit RGB555 pixels into the SDRAM
// framebuffer shared with the VGA scan-out path. Two pixels share each 32-bit
// word, with the even-x pixel in bits [15:0]. The block accepts single pixel
// writes over a valid/ready handshake and runs a hardware full-frame fill.
//
// Parameters:
//   H_PIXELS           visible pixels per line (must be even)
//   V_PIXELS           visible lines
//
// Ports:
//   clk                system clock
//   rst_n              asynchronous active-low reset
//   fbAddr             framebuffer byte base address, bits [1:0] ignored
//   pix_valid          pixel request valid
//   pix_ready          block can accept a pixel this cycle (IDLE only)
//   pix_x / pix_y      pixel column / row
//   pix_color          RGB555 pixel, bit 15 stored but not displayed
//   clear_start        single-cycle full-frame fill request
//   clear_color        fill colour, sampled with clear_start
//   clear_busy         fill pending or running
//   drop_count         saturating count of out-of-range pixels dropped
//   master_address     word-aligned byte address
//   master_write       Avalon write request
//   master_writedata   write data
//   master_byteenable  byte lanes to write
//   master_waitrequest Avalon stall
// ----------------------------------------------------------------------------
module fb_pixel_writer #(
    parameter int H_PIXELS = 640,
    parameter int V_PIXELS = 480
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] fbAddr,
    input  logic        pix_valid,
    output logic        pix_ready,
    input  logic [9:0]  pix_x,
    input  logic [8:0]  pix_y,
    input  logic [15:0] pix_color,
    input  logic        clear_start,
    input  logic [15:0] clear_color,
    output logic        clear_busy,
    output logic [15:0] drop_count,
    output logic [31:0] master_address,
    output logic        master_write,
    output logic [31:0] master_writedata,
    output logic [3:0]  master_byteenable,
    input  logic        master_waitrequest
);

    localparam int          N_WORDS  = H_PIXELS * V_PIXELS / 2;
    localparam logic [17:0] LAST_IDX = 18'(N_WORDS - 1);
    localparam logic [31:0] H_U      = 32'(H_PIXELS);
    localparam logic [31:0] V_U      = 32'(V_PIXELS);

    typedef enum logic [1:0] {
        IDLE,
        PIX_WR,
        CLEAR
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pixAddr_q, pixAddr_d;
    logic [15:0] pixColor_q, pixColor_d;
    logic [3:0]  pixBe_q, pixBe_d;
    logic [15:0] clearColor_q, clearColor_d;
    logic [31:0] clearBase_q, clearBase_d;
    logic        clearPending_q, clearPending_d;
    logic [17:0] idx_q, idx_d;
    logic [15:0] dropCount_q, dropCount_d;

    logic        pixAccept;
    logic        pixInRange;
    logic [31:0] pixIndex;
    logic [31:0] pixTarget;

    // Linear pixel index and the byte address it maps to; the multiply is by a
    // constant so it reduces to shifts and adds. The wrap at 2^32 is natural.
    assign pixAccept  = pix_valid && (state_q == IDLE);
    assign pixInRange = (32'(pix_x) < H_U) && (32'(pix_y) < V_U);
    assign pixIndex   = 32'(pix_y) * H_U + 32'(pix_x);
    assign pixTarget  = (fbAddr & ~32'h3) + (pixIndex << 1);

    // Next-state logic. A clear request seen outside CLEAR is latched with its
    // own base so a later fbAddr change cannot move the fill. A pixel accepted
    // in the same cycle as clear_start wins the bus first; the pending flag
    // then steers PIX_WR into CLEAR instead of back to IDLE.
    always_comb begin
        state_d        = state_q;
        pixAddr_d      = pixAddr_q;
        pixColor_d     = pixColor_q;
        pixBe_d        = pixBe_q;
        clearColor_d   = clearColor_q;
        clearBase_d    = clearBase_q;
        clearPending_d = clearPending_q;
        idx_d          = idx_q;
        dropCount_d    = dropCount_q;

        if (clear_start && (state_q != CLEAR)) begin
            clearColor_d   = clear_color;
            clearBase_d    = fbAddr & ~32'h3;
            clearPending_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (pixAccept && pixInRange) begin
                    pixAddr_d  = pixTarget & ~32'h3;
                    pixColor_d = pix_color;
                    pixBe_d    = pix_x[0] ? 4'b1100 : 4'b0011;
                    state_d    = PIX_WR;
                end else if (clear_start) begin
                    state_d = CLEAR;
                end
                if (pixAccept && !pixInRange && (dropCount_q != 16'hFFFF)) begin
                    dropCount_d = dropCount_q + 16'd1;
                end
            end
            PIX_WR: begin
                if (!master_waitrequest) begin
                    state_d = (clearPending_q || clear_start) ? CLEAR : IDLE;
                end
            end
            CLEAR: begin
                if (!master_waitrequest) begin
                    if (idx_q == LAST_IDX) begin
                        state_d        = IDLE;
                        clearPending_d = 1'b0;
                        idx_d          = 18'd0;
                    end else begin
                        idx_d = idx_q + 18'd1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset abandons any write or fill at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            pixAddr_q      <= 32'd0;
            pixColor_q     <= 16'd0;
            pixBe_q        <= 4'd0;
            clearColor_q   <= 16'd0;
            clearBase_q    <= 32'd0;
            clearPending_q <= 1'b0;
            idx_q          <= 18'd0;
            dropCount_q    <= 16'd0;
        end else begin
            state_q        <= state_d;
            pixAddr_q      <= pixAddr_d;
            pixColor_q     <= pixColor_d;
            pixBe_q        <= pixBe_d;
            clearColor_q   <= clearColor_d;
            clearBase_q    <= clearBase_d;
            clearPending_q <= clearPending_d;
            idx_q          <= idx_d;
            dropCount_q    <= dropCount_d;
        end
    end

    // Bus outputs come only from registered state, so they hold steady across
    // a stall and pix_ready has no path from any input. IDLE drives zeros.
    always_comb begin
        master_write      = 1'b0;
        master_address    = 32'd0;
        master_writedata  = 32'd0;
        master_byteenable = 4'd0;
        case (state_q)
            PIX_WR: begin
                master_write      = 1'b1;
                master_address    = pixAddr_q;
                master_writedata  = {pixColor_q, pixColor_q};
                master_byteenable = pixBe_q;
            end
            CLEAR: begin
                master_write      = 1'b1;
                master_address    = clearBase_q + {12'd0, idx_q, 2'b00};
                master_writedata  = {clearColor_q, clearColor_q};
                master_byteenable = 4'b1111;
            end
            default: begin
                master_write = 1'b0;
            end
        endcase
    end

    assign pix_ready  = (state_q == IDLE);
    assign clear_busy = clearPending_q || (state_q == CLEAR);
    assign drop_count = dropCount_q;

endmodule

// File: tb/tb_fb_pixel_writer.sv
// ----------------------------------------------------------------------------
// tb_fb_pixel_writer
//
// Directed self-checking bench for fb_pixel_writer. The frame is shrunk to
// 640x16 so full fills stay short while keeping the 640-wide address math.
// Inputs change and outputs are sampled on the falling clock edge.
// ----------------------------------------------------------------------------
module tb_fb_pixel_writer;

    localparam int H = 640;
    localparam int V = 16;
    localparam int N = H * V / 2;

    logic        clk;
    logic        rst_n;
    logic [31:0] fbAddr;
    logic        pix_valid;
    logic        pix_ready;
    logic [9:0]  pix_x;
    logic [8:0]  pix_y;
    logic [15:0] pix_color;
    logic        clear_start;
    logic [15:0] clear_color;
    logic        clear_busy;
    logic [15:0] drop_count;
    logic [31:0] master_address;
    logic        master_write;
    logic [31:0] master_writedata;
    logic [3:0]  master_byteenable;
    logic        master_waitrequest;

    int checks = 0;
    int errors = 0;

    fb_pixel_writer #(
        .H_PIXELS(H),
        .V_PIXELS(V)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .fbAddr            (fbAddr),
        .pix_valid         (pix_valid),
        .pix_ready         (pix_ready),
        .pix_x             (pix_x),
        .pix_y             (pix_y),
        .pix_color         (pix_color),
        .clear_start       (clear_start),
        .clear_color       (clear_color),
        .clear_busy        (clear_busy),
        .drop_count        (drop_count),
        .master_address    (master_address),
        .master_write      (master_write),
        .master_writedata  (master_writedata),
        .master_byteenable (master_byteenable),
        .master_waitrequest(master_waitrequest)
    );

    // Free-running 100 MHz clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present one pixel request for a single cycle, returning at the next
    // falling edge (the cycle after the accept edge).
    task automatic applyStimulus(input logic [9:0] x, input logic [8:0] y, input logic [15:0] c);
        pix_valid = 1'b1;
        pix_x     = x;
        pix_y     = y;
        pix_color = c;
        @(negedge clk);
        pix_valid = 1'b0;
    endtask

    // Follow a running fill with random stalls until clear_busy drops, counting
    // accepted writes and address/data deviations from the expected sequence.
    // Optionally fires one extra clear_start (with a different colour and base)
    // once pulseAt writes have been accepted.
    task automatic runClear(input logic [31:0] base, input logic [31:0] data, input int pulseAt,
                            output int writes, output int badAddr, output int badData,
                            output int fallGap, output bit timedOut);
        int cyc = 0;
        int lastAcc = -10;
        bit pulsed = 1'b0;
        writes   = 0;
        badAddr  = 0;
        badData  = 0;
        timedOut = 1'b0;
        while (clear_busy === 1'b1 && !timedOut) begin
            master_waitrequest = 1'($urandom_range(0, 1));
            if (pulseAt >= 0 && writes == pulseAt && !pulsed) begin
                clear_start = 1'b1;
                clear_color = 16'h0001;
                fbAddr      = 32'h0030_0000;
                pulsed      = 1'b1;
            end
            if (master_write === 1'b1 && !master_waitrequest) begin
                if (master_address !== base + 32'(writes * 4) || master_byteenable !== 4'b1111)
                    badAddr++;
                if (master_writedata !== data)
                    badData++;
                writes++;
                lastAcc = cyc;
            end
            @(negedge clk);
            clear_start = 1'b0;
            cyc++;
            if (cyc > 40000) timedOut = 1'b1;
        end
        fallGap = cyc - lastAcc;
        master_waitrequest = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        fbAddr = 32'd0; pix_valid = 1'b0; pix_x = '0; pix_y = '0; pix_color = '0;
        clear_start = 1'b0; clear_color = '0; master_waitrequest = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (pix_ready !== 1'b1 || master_write !== 1'b0 || clear_busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_ctrl: ready/write/busy = %b%b%b, expected 100", pix_ready, master_write, clear_busy);
        end
        checks++;
        if (master_address !== 32'd0 || master_writedata !== 32'd0 || master_byteenable !== 4'd0) begin
            errors++;
            $display("[TB] FAIL reset_bus: addr %h data %h be %b, expected zeros", master_address, master_writedata, master_byteenable);
        end
        checks++;
        if (drop_count !== 16'd0) begin
            errors++;
            $display("[TB] FAIL reset_drop: drop_count %0d, expected 0", drop_count);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single_pixel();
        fbAddr = 32'h0010_0000;
        applyStimulus(10'd3, 9'd2, 16'h7C00);
        checks++;
        if (master_write !== 1'b1 || master_address !== 32'h0010_0A04) begin
            errors++;
            $display("[TB] FAIL single_addr: write %b addr %h, expected 1 00100a04", master_write, master_address);
        end
        checks++;
        if (master_writedata !== 32'h7C00_7C00 || master_byteenable !== 4'b1100) begin
            errors++;
            $display("[TB] FAIL single_data: data %h be %b, expected 7c007c00 1100", master_writedata, master_byteenable);
        end
        checks++;
        if (pix_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL single_ready_low: pix_ready %b, expected 0", pix_ready);
        end
        @(negedge clk);
        checks++;
        if (pix_ready !== 1'b1 || master_write !== 1'b0) begin
            errors++;
            $display("[TB] FAIL single_ready_back: ready %b write %b, expected 1 0", pix_ready, master_write);
        end
    endtask

    task automatic test_wait_states();
        int n = 0;
        int bad = 0;
        master_waitrequest = 1'b1;
        applyStimulus(10'd0, 9'd0, 16'h001F);
        fbAddr = 32'h0ABC_0000;
        while (master_write === 1'b1 && n < 20) begin
            if (master_address !== 32'h0010_0000 || master_byteenable !== 4'b0011 ||
                master_writedata !== 32'h001F_001F || pix_ready !== 1'b0)
                bad++;
            master_waitrequest = (n < 5);
            n++;
            @(negedge clk);
        end
        checks++;
        if (n != 6) begin
            errors++;
            $display("[TB] FAIL wait_cycles: master_write held %0d cycles, expected 6", n);
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("[TB] FAIL wait_stable: %0d unstable cycles, expected 0", bad);
        end
        checks++;
        if (pix_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL wait_idle: pix_ready %b, expected 1", pix_ready);
        end
        fbAddr = 32'h0010_0000;
        master_waitrequest = 1'b0;
    endtask

    task automatic test_out_of_range();
        applyStimulus(10'd640, 9'd0, 16'h1111);
        checks++;
        if (master_write !== 1'b0 || pix_ready !== 1'b1 || drop_count !== 16'd1) begin
            errors++;
            $display("[TB] FAIL oor_x: write %b ready %b drop %0d, expected 0 1 1", master_write, pix_ready, drop_count);
        end
        applyStimulus(10'd0, 9'd480, 16'h2222);
        checks++;
        if (master_write !== 1'b0 || drop_count !== 16'd2) begin
            errors++;
            $display("[TB] FAIL oor_y: write %b drop %0d, expected 0 2", master_write, drop_count);
        end
        applyStimulus(10'd0, 9'(V), 16'h3333);
        checks++;
        if (master_write !== 1'b0 || drop_count !== 16'd3) begin
            errors++;
            $display("[TB] FAIL oor_y_edge: write %b drop %0d, expected 0 3", master_write, drop_count);
        end
        applyStimulus(10'd639, 9'(V - 1), 16'h4444);
        checks++;
        if (master_write !== 1'b1 || master_address !== 32'h0010_4FFC || master_byteenable !== 4'b1100) begin
            errors++;
            $display("[TB] FAIL corner_pixel: write %b addr %h be %b, expected 1 00104ffc 1100", master_write, master_address, master_byteenable);
        end
        checks++;
        if (drop_count !== 16'd3) begin
            errors++;
            $display("[TB] FAIL corner_nodrop: drop %0d, expected 3", drop_count);
        end
        @(negedge clk);
    endtask

    task automatic test_full_clear();
        int writes, badAddr, badData, fallGap;
        bit timedOut;
        fbAddr      = 32'h0010_0000;
        clear_color = 16'h03E0;
        clear_start = 1'b1;
        @(negedge clk);
        clear_start = 1'b0;
        checks++;
        if (clear_busy !== 1'b1 || pix_ready !== 1'b0 || master_write !== 1'b1) begin
            errors++;
            $display("[TB] FAIL clear_begin: busy %b ready %b write %b, expected 1 0 1", clear_busy, pix_ready, master_write);
        end
        pix_valid = 1'b1; pix_x = 10'd5; pix_y = 9'd1; pix_color = 16'h1234;
        runClear(32'h0010_0000, 32'h03E0_03E0, -1, writes, badAddr, badData, fallGap, timedOut);
        checks++;
        if (timedOut || writes != N) begin
            errors++;
            $display("[TB] FAIL clear_count: %0d writes (timeout %0d), expected %0d", writes, timedOut, N);
        end
        checks++;
        if (badAddr != 0 || badData != 0) begin
            errors++;
            $display("[TB] FAIL clear_words: %0d bad addr/be, %0d bad data, expected 0 0", badAddr, badData);
        end
        checks++;
        if (fallGap != 1) begin
            errors++;
            $display("[TB] FAIL clear_busy_fall: busy fell %0d cycles after last write, expected 1", fallGap);
        end
        checks++;
        if (pix_ready !== 1'b1 || master_write !== 1'b0) begin
            errors++;
            $display("[TB] FAIL clear_end_idle: ready %b write %b, expected 1 0", pix_ready, master_write);
        end
        @(negedge clk);
        pix_valid = 1'b0;
        checks++;
        if (master_write !== 1'b1 || master_address !== 32'h0010_0508 ||
            master_writedata !== 32'h1234_1234 || master_byteenable !== 4'b1100) begin
            errors++;
            $display("[TB] FAIL stalled_pixel: write %b addr %h data %h be %b, expected 1 00100508 12341234 1100",
                     master_write, master_address, master_writedata, master_byteenable);
        end
        @(negedge clk);
        checks++;
        if (master_write !== 1'b0 || drop_count !== 16'd3) begin
            errors++;
            $display("[TB] FAIL stalled_done: write %b drop %0d, expected 0 3", master_write, drop_count);
        end
    endtask

    task automatic test_simultaneous();
        int writes, badAddr, badData, fallGap;
        bit timedOut;
        fbAddr      = 32'h0020_0000;
        clear_color = 16'h7FFF;
        clear_start = 1'b1;
        applyStimulus(10'd2, 9'd0, 16'hABCD);
        clear_start = 1'b0;
        checks++;
        if (master_write !== 1'b1 || master_address !== 32'h0020_0004 ||
            master_writedata !== 32'hABCD_ABCD || master_byteenable !== 4'b0011) begin
            errors++;
            $display("[TB] FAIL simul_pixel_first: write %b addr %h data %h be %b, expected 1 00200004 abcdabcd 0011",
                     master_write, master_address, master_writedata, master_byteenable);
        end
        checks++;
        if (clear_busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL simul_busy: clear_busy %b, expected 1", clear_busy);
        end
        fbAddr = 32'h0040_0000;
        @(negedge clk);
        runClear(32'h0020_0000, 32'h7FFF_7FFF, 100, writes, badAddr, badData, fallGap, timedOut);
        checks++;
        if (timedOut || writes != N) begin
            errors++;
            $display("[TB] FAIL simul_count: %0d writes (timeout %0d), expected %0d", writes, timedOut, N);
        end
        checks++;
        if (badAddr != 0 || badData != 0) begin
            errors++;
            $display("[TB] FAIL simul_words: %0d bad addr/be, %0d bad data, expected 0 0", badAddr, badData);
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (master_write !== 1'b0 || clear_busy !== 1'b0) begin
                errors++;
                $display("[TB] FAIL simul_no_restart: cycle %0d write %b busy %b, expected 0 0", i, master_write, clear_busy);
            end
            @(negedge clk);
        end
        fbAddr = 32'h0010_0000;
    endtask

    task automatic test_reset_mid_clear();
        int k = 0;
        int cyc = 0;
        clear_color = 16'h5555;
        clear_start = 1'b1;
        @(negedge clk);
        clear_start = 1'b0;
        while (k < 1000 && cyc < 5000) begin
            if (master_write === 1'b1) k++;
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (master_address !== 32'h0010_0FA0 || clear_busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL midclear_pos: addr %h busy %b, expected 00100fa0 1", master_address, clear_busy);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (master_write !== 1'b0 || clear_busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL midclear_abort: write %b busy %b, expected 0 0", master_write, clear_busy);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (pix_ready !== 1'b1 || master_write !== 1'b0 || clear_busy !== 1'b0 || drop_count !== 16'd0) begin
            errors++;
            $display("[TB] FAIL midclear_after: ready %b write %b busy %b drop %0d, expected 1 0 0 0",
                     pix_ready, master_write, clear_busy, drop_count);
        end
    endtask

    // Scenario sequence followed by the summary line.
    initial begin
        $display("[TB] starting fb_pixel_writer bench (frame %0dx%0d, %0d words)", H, V, N);
        test_reset();
        test_single_pixel();
        test_wait_states();
        test_out_of_range();
        test_full_clear();
        test_simultaneous();
        test_reset_mid_clear();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
